drum_step_sequencer: RTL and testbench
======================================

Name: drum_step_sequencer

Overview:
- Upstream stage of the drum-grid colour mapper.
- Turns USB-keyboard keycodes into the 4-channel × 12-step pattern state, the selected channel and the playhead.
- Runs the tempo-driven step counter and emits per-channel one-cycle trigger pulses for the sample-playback block.
- Drives the mapper's channelnum, channel0..channel3, BallX, BallY and Ball_size inputs directly.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- BPM_DEFAULT, 120, tempo after reset.
- BPM_MIN, 60, lower tempo bound.
- BPM_MAX, 240, upper tempo bound.
- BPM_STEP, 4, tempo change per key event.

Ports:
- Clk  in  1  system clock; single clock domain.
- Reset_n  in  1  asynchronous, active-low reset.
- keycode  in  8  current USB HID keycode; 0 = no key.
- channelnum  out  4  selected channel, 0..3.
- channel0..channel3  out  12 each  step pattern per channel; bit s = step s armed.
- step  out  4  current playhead step, 0..11.
- playing  out  1  sequencer running.
- bpm  out  8  current tempo.
- trig  out  4  one-cycle pulse per channel on step entry.
- BallX, BallY, Ball_size  out  10 each  playhead bar geometry.

Behaviour:
Clock and reset
- One clock, Clk. Reset_n is asynchronous and active-low.
- Reset values: channelnum 0; channel0..3 all 0; step 0; playing 0; bpm BPM_DEFAULT; trig 0; phase accumulator 0; keycode history register 0.

Key events
- keycode is registered every cycle into prev_key.
- An event occurs in a cycle where keycode != prev_key and keycode != 0. Holding a key produces exactly one event.
- Each event is acted on at the same clock edge at which it is detected.
- Event decode:
  - 0x1E/0x1F/0x20/0x21 ('1'..'4'): channelnum ← 0/1/2/3.
  - 0x14,0x1A,0x08,0x15,0x17,0x1C,0x18,0x0C,0x12,0x13,0x2F,0x30 (Q W E R T Y U I O P [ ]): toggle bit 0..11, in that order, of the selected channel's pattern.
  - 0x2A (Backspace): selected pattern ← 0.
  - 0x2C (Space): toggle playing.
  - 0x28 (Enter): step ← 0, accumulator ← 0; playing unchanged; no trig.
  - 0x2E ('='): bpm ← min(bpm + BPM_STEP, BPM_MAX).
  - 0x2D ('-'): bpm ← max(bpm − BPM_STEP, BPM_MIN).
  - All other codes are ignored.

Tempo (phase accumulator, sixteenth notes, no divider)
- LIMIT = 15*CLK_HZ. Accumulator is 30 bits; its sum is 31 bits.
- While playing, each cycle: sum = acc + bpm.
  - If sum ≥ LIMIT: acc ← sum − LIMIT and an advance occurs.
  - Otherwise acc ← sum.
- While stopped, acc holds 0.

Advance
- step ← (step == 11) ? 0 : step + 1.
- At the same edge, trig[c] ← channelc[next_step] for each channel c. trig is 0 in every other cycle.

Start and stop
- Space while stopped: playing ← 1 and acc ← 0. At the same edge, trig[c] ← channelc[step] for the current step, which does not advance.
- Space while playing: playing ← 0, acc ← 0, step held, trig 0.

Simultaneous events
- Pattern reads for trig use the pre-edge register values. A toggle landing on the same edge as an advance into that step does not affect that step's trig.
- Enter on the same edge as an advance: Enter wins, so step = 0 and trig = 0.
- The tempo change applies from the next cycle's add.
- Reset mid-play: all state returns to reset values immediately; no trig glitch.

Playhead geometry (combinational from the step register, zero added latency)
- BallX = 112 + 42*step.
- BallY = 233 (constant).
- Ball_size = 14 (constant).
- Arithmetic is 10-bit unsigned; the maximum BallX, at step 11, is 574.

Test Plan:
1. Reset_n low then high → all outputs at reset values; BallX = 112, bpm = 120, channel0..3 = 0.
2. keycode 0x1F held 50 cycles, then 0x1A, then 0 → channelnum = 1; channel1 = 12'h002 (toggled once only); other channels 0.
3. CLK_HZ = 1500, bpm = 60; set channel0 = 12'h001; Space.
   - Immediate trig = 4'b0001.
   - Advances every 375 cycles.
   - After 12 advances step wraps 11→0 with trig[0] = 1; BallX follows 112, 154, … 574, 112.
4. '=' pressed 50 times from 120 → bpm saturates at 240. '-' pressed 50 times → bpm saturates at 60.
5. While playing, press Enter on the same cycle an advance is due → step = 0, trig = 0. Press Backspace → selected pattern = 0 and no trig fires on subsequent steps.
6. Assert Reset_n mid-play at step 7 → step = 0, playing = 0, trig = 0 within the same cycle (asynchronous reset).

Source files
------------

// File: rtl/drum_step_sequencer.sv
// Drum step sequencer: turns USB keycodes into a 4-channel x 12-step pattern,
// runs the tempo-driven playhead and emits one-cycle per-channel trigger pulses.
module drum_step_sequencer #(
  parameter int unsigned CLK_HZ      = 50000000,
  parameter int unsigned BPM_DEFAULT = 120,
  parameter int unsigned BPM_MIN     = 60,
  parameter int unsigned BPM_MAX     = 240,
  parameter int unsigned BPM_STEP    = 4
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [7:0]  keycode,
  output logic [3:0]  channelnum,
  output logic [11:0] channel0,
  output logic [11:0] channel1,
  output logic [11:0] channel2,
  output logic [11:0] channel3,
  output logic [3:0]  step,
  output logic        playing,
  output logic [7:0]  bpm,
  output logic [3:0]  trig,
  output logic [9:0]  BallX,
  output logic [9:0]  BallY,
  output logic [9:0]  Ball_size
);

  // One sixteenth note elapses when bpm has been summed 15*CLK_HZ times over.
  localparam logic [30:0] LIMIT = 31'(15 * CLK_HZ);

  localparam logic [7:0] KEY_1     = 8'h1E;
  localparam logic [7:0] KEY_2     = 8'h1F;
  localparam logic [7:0] KEY_3     = 8'h20;
  localparam logic [7:0] KEY_4     = 8'h21;
  localparam logic [7:0] KEY_BKSP  = 8'h2A;
  localparam logic [7:0] KEY_SPACE = 8'h2C;
  localparam logic [7:0] KEY_ENTER = 8'h28;
  localparam logic [7:0] KEY_PLUS  = 8'h2E;
  localparam logic [7:0] KEY_MINUS = 8'h2D;

  logic [7:0]       prevKey_q;
  logic [1:0]       selChan_q, selChan_d;
  logic [3:0][11:0] pattern_q, pattern_d;
  logic [3:0]       step_q, step_d;
  logic             playing_q, playing_d;
  logic [7:0]       bpm_q, bpm_d;
  logic [29:0]      acc_q, acc_d;
  logic [3:0]       trig_q, trig_d;

  logic        keyEvent;
  logic        toggleHit;
  logic [3:0]  toggleIdx;
  logic [30:0] phaseSum;
  logic        advanceDue;
  logic [3:0]  nextStep;
  logic [8:0]  bpmUp;

  assign keyEvent   = (keycode != prevKey_q) && (keycode != 8'h00);
  assign phaseSum   = {1'b0, acc_q} + 31'(bpm_q);
  assign advanceDue = playing_q && (phaseSum >= LIMIT);
  assign nextStep   = (step_q == 4'd11) ? 4'd0 : step_q + 4'd1;
  assign bpmUp      = {1'b0, bpm_q} + 9'(BPM_STEP);

  // Map the twelve step keys (Q..P, [, ]) to the pattern bit they toggle.
  always_comb begin
    toggleHit = 1'b1;
    toggleIdx = 4'd0;
    case (keycode)
      8'h14:   toggleIdx = 4'd0;
      8'h1A:   toggleIdx = 4'd1;
      8'h08:   toggleIdx = 4'd2;
      8'h15:   toggleIdx = 4'd3;
      8'h17:   toggleIdx = 4'd4;
      8'h1C:   toggleIdx = 4'd5;
      8'h18:   toggleIdx = 4'd6;
      8'h0C:   toggleIdx = 4'd7;
      8'h12:   toggleIdx = 4'd8;
      8'h13:   toggleIdx = 4'd9;
      8'h2F:   toggleIdx = 4'd10;
      8'h30:   toggleIdx = 4'd11;
      default: toggleHit = 1'b0;
    endcase
  end

  // Next-state: tempo advance first, then a key event may override it.
  always_comb begin
    selChan_d = selChan_q;
    pattern_d = pattern_q;
    step_d    = step_q;
    playing_d = playing_q;
    bpm_d     = bpm_q;
    acc_d     = acc_q;
    trig_d    = 4'b0000;

    if (playing_q) begin
      if (advanceDue) begin
        acc_d  = 30'(phaseSum - LIMIT);
        step_d = nextStep;
        for (int c = 0; c < 4; c++) begin
          trig_d[c] = pattern_q[c][nextStep];
        end
      end else begin
        acc_d = 30'(phaseSum);
      end
    end else begin
      acc_d = '0;
    end

    if (keyEvent) begin
      if (toggleHit) begin
        pattern_d[selChan_q][toggleIdx] = ~pattern_q[selChan_q][toggleIdx];
      end
      case (keycode)
        KEY_1:    selChan_d = 2'd0;
        KEY_2:    selChan_d = 2'd1;
        KEY_3:    selChan_d = 2'd2;
        KEY_4:    selChan_d = 2'd3;
        KEY_BKSP: pattern_d[selChan_q] = '0;
        KEY_SPACE: begin
          acc_d = '0;
          if (playing_q) begin
            playing_d = 1'b0;
            step_d    = step_q;
            trig_d    = 4'b0000;
          end else begin
            playing_d = 1'b1;
            for (int c = 0; c < 4; c++) begin
              trig_d[c] = pattern_q[c][step_q];
            end
          end
        end
        KEY_ENTER: begin
          step_d = 4'd0;
          acc_d  = '0;
          trig_d = 4'b0000;
        end
        KEY_PLUS:  bpm_d = (bpmUp > 9'(BPM_MAX)) ? 8'(BPM_MAX) : bpmUp[7:0];
        KEY_MINUS: bpm_d = (bpm_q < 8'(BPM_MIN + BPM_STEP)) ? 8'(BPM_MIN)
                                                             : bpm_q - 8'(BPM_STEP);
        default: ;
      endcase
    end
  end

  // State registers, cleared asynchronously so a reset mid-play drops trig at once.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      prevKey_q <= 8'h00;
      selChan_q <= 2'd0;
      pattern_q <= '0;
      step_q    <= 4'd0;
      playing_q <= 1'b0;
      bpm_q     <= 8'(BPM_DEFAULT);
      acc_q     <= '0;
      trig_q    <= 4'b0000;
    end else begin
      prevKey_q <= keycode;
      selChan_q <= selChan_d;
      pattern_q <= pattern_d;
      step_q    <= step_d;
      playing_q <= playing_d;
      bpm_q     <= bpm_d;
      acc_q     <= acc_d;
      trig_q    <= trig_d;
    end
  end

  assign channelnum = {2'b00, selChan_q};
  assign channel0   = pattern_q[0];
  assign channel1   = pattern_q[1];
  assign channel2   = pattern_q[2];
  assign channel3   = pattern_q[3];
  assign step       = step_q;
  assign playing    = playing_q;
  assign bpm        = bpm_q;
  assign trig       = trig_q;

  // Playhead bar sits at a fixed row and slides 42 pixels per step.
  assign BallX     = 10'd112 + 10'd42 * {6'd0, step_q};
  assign BallY     = 10'd233;
  assign Ball_size = 10'd14;

endmodule

// File: tb/tb_drum_step_sequencer.sv
// Self-checking bench for drum_step_sequencer with a small clock rate so a
// sixteenth note at 60 bpm lasts exactly 375 cycles.
module tb_drum_step_sequencer;

  localparam int CLK_HZ = 1500;
  localparam int LIMIT  = 15 * CLK_HZ;

  logic        Clk;
  logic        Reset_n;
  logic [7:0]  keycode;
  logic [3:0]  channelnum;
  logic [11:0] channel0, channel1, channel2, channel3;
  logic [3:0]  step;
  logic        playing;
  logic [7:0]  bpm;
  logic [3:0]  trig;
  logic [9:0]  BallX, BallY, Ball_size;

  int checkCount = 0;
  int errorCount = 0;
  bit compareOn  = 0;

  drum_step_sequencer #(
    .CLK_HZ(CLK_HZ), .BPM_DEFAULT(120), .BPM_MIN(60), .BPM_MAX(240), .BPM_STEP(4)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .keycode(keycode),
    .channelnum(channelnum),
    .channel0(channel0), .channel1(channel1), .channel2(channel2), .channel3(channel3),
    .step(step), .playing(playing), .bpm(bpm), .trig(trig),
    .BallX(BallX), .BallY(BallY), .Ball_size(Ball_size)
  );

  // Free-running clock
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Reference model state
  logic [7:0]  toggleKeys [12] = '{8'h14, 8'h1A, 8'h08, 8'h15, 8'h17, 8'h1C,
                                   8'h18, 8'h0C, 8'h12, 8'h13, 8'h2F, 8'h30};
  logic [11:0] mdlPat [4];
  logic [11:0] oldPat [4];
  int          mdlSel, mdlStep, mdlBpm, oldStep;
  longint      mdlAcc;
  bit          mdlPlaying, wasPlaying, isEvent;
  logic [3:0]  mdlTrig;
  logic [7:0]  mdlPrev;

  // Reference model: sequencer behaviour written as plain per-edge rules
  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int c = 0; c < 4; c++) mdlPat[c] = 12'h000;
      mdlSel = 0; mdlStep = 0; mdlBpm = 120; mdlAcc = 0;
      mdlPlaying = 0; mdlTrig = 4'b0000; mdlPrev = 8'h00;
    end else begin
      wasPlaying = mdlPlaying;
      oldStep    = mdlStep;
      for (int c = 0; c < 4; c++) oldPat[c] = mdlPat[c];
      isEvent = (keycode != mdlPrev) && (keycode != 8'h00);
      mdlPrev = keycode;
      mdlTrig = 4'b0000;
      if (wasPlaying) begin
        mdlAcc = mdlAcc + mdlBpm;
        if (mdlAcc >= LIMIT) begin
          mdlAcc  = mdlAcc - LIMIT;
          mdlStep = (mdlStep + 1) % 12;
          for (int c = 0; c < 4; c++) mdlTrig[c] = oldPat[c][mdlStep];
        end
      end else begin
        mdlAcc = 0;
      end
      if (isEvent) begin
        for (int i = 0; i < 12; i++)
          if (keycode == toggleKeys[i]) mdlPat[mdlSel][i] = ~mdlPat[mdlSel][i];
        case (keycode)
          8'h1E: mdlSel = 0;
          8'h1F: mdlSel = 1;
          8'h20: mdlSel = 2;
          8'h21: mdlSel = 3;
          8'h2A: mdlPat[mdlSel] = 12'h000;
          8'h2C: begin
            mdlAcc = 0;
            if (wasPlaying) begin
              mdlPlaying = 0; mdlStep = oldStep; mdlTrig = 4'b0000;
            end else begin
              mdlPlaying = 1;
              for (int c = 0; c < 4; c++) mdlTrig[c] = oldPat[c][oldStep];
            end
          end
          8'h28: begin mdlStep = 0; mdlAcc = 0; mdlTrig = 4'b0000; end
          8'h2E: mdlBpm = (mdlBpm + 4 > 240) ? 240 : mdlBpm + 4;
          8'h2D: mdlBpm = (mdlBpm - 4 < 60) ? 60 : mdlBpm - 4;
          default: ;
        endcase
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Every-cycle comparison of all outputs against the model
  always @(negedge Clk) begin
    if (compareOn) begin
      checkOutput("mdl_channelnum", 32'(channelnum), 32'(mdlSel));
      checkOutput("mdl_channel0", 32'(channel0), 32'(mdlPat[0]));
      checkOutput("mdl_channel1", 32'(channel1), 32'(mdlPat[1]));
      checkOutput("mdl_channel2", 32'(channel2), 32'(mdlPat[2]));
      checkOutput("mdl_channel3", 32'(channel3), 32'(mdlPat[3]));
      checkOutput("mdl_step", 32'(step), 32'(mdlStep));
      checkOutput("mdl_playing", 32'(playing), 32'(mdlPlaying));
      checkOutput("mdl_bpm", 32'(bpm), 32'(mdlBpm));
      checkOutput("mdl_trig", 32'(trig), 32'(mdlTrig));
      checkOutput("mdl_BallX", 32'(BallX), 32'(112 + 42 * mdlStep));
      checkOutput("mdl_BallY", 32'(BallY), 32'd233);
      checkOutput("mdl_Ball_size", 32'(Ball_size), 32'd14);
    end
  end

  // Hold a key for the given number of edges, then release it for one edge
  task automatic applyStimulus(input logic [7:0] key, input int holdCycles);
    @(negedge Clk);
    keycode = key;
    repeat (holdCycles) @(posedge Clk);
    @(negedge Clk);
    keycode = 8'h00;
    @(posedge Clk);
  endtask

  int ballTable [12] = '{154, 196, 238, 280, 322, 364, 406, 448, 490, 532, 574, 112};
  int n, trigSeen, found;
  logic [3:0] prevStep;

  // Directed scenario
  initial begin
    Reset_n = 1'b0;
    keycode = 8'h00;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    Reset_n   = 1'b1;
    compareOn = 1;

    @(negedge Clk);
    $display("[TB] reset values");
    checkOutput("rst_BallX", 32'(BallX), 32'd112);
    checkOutput("rst_bpm", 32'(bpm), 32'd120);
    checkOutput("rst_channels", 32'({channel0, channel1}), 32'd0);
    checkOutput("rst_channels23", 32'({channel2, channel3}), 32'd0);
    checkOutput("rst_playing_step_trig", 32'({playing, step, trig}), 32'd0);

    $display("[TB] held keys act once");
    applyStimulus(8'h1F, 50);
    applyStimulus(8'h1A, 10);
    @(negedge Clk);
    checkOutput("sel_channelnum", 32'(channelnum), 32'd1);
    checkOutput("sel_channel1", 32'(channel1), 32'h002);
    checkOutput("sel_channel0", 32'(channel0), 32'h000);

    $display("[TB] tempo saturation");
    repeat (50) applyStimulus(8'h2E, 1);
    @(negedge Clk);
    checkOutput("bpm_max", 32'(bpm), 32'd240);
    repeat (50) applyStimulus(8'h2D, 1);
    @(negedge Clk);
    checkOutput("bpm_min", 32'(bpm), 32'd60);

    $display("[TB] play at 60 bpm");
    applyStimulus(8'h1E, 1);
    applyStimulus(8'h14, 1);
    @(negedge Clk);
    checkOutput("arm_channel0", 32'(channel0), 32'h001);
    keycode = 8'h2C;
    @(posedge Clk); #1;
    checkOutput("start_trig", 32'(trig), 32'b0001);
    checkOutput("start_playing", 32'(playing), 32'd1);
    checkOutput("start_step", 32'(step), 32'd0);
    @(negedge Clk);
    keycode = 8'h00;
    for (int k = 0; k < 12; k++) begin
      n = 0;
      prevStep = step;
      do begin
        @(posedge Clk); #1;
        n++;
      end while (step == prevStep && n < 400);
      checkOutput("advance_interval", 32'(n), 32'd375);
      checkOutput("advance_BallX", 32'(BallX), 32'(ballTable[k]));
    end
    checkOutput("wrap_step", 32'(step), 32'd0);
    checkOutput("wrap_trig", 32'(trig), 32'b0001);

    $display("[TB] enter collides with advance");
    repeat (374) @(posedge Clk);
    @(negedge Clk);
    keycode = 8'h28;
    @(posedge Clk); #1;
    checkOutput("enter_step", 32'(step), 32'd0);
    checkOutput("enter_trig", 32'(trig), 32'd0);
    @(negedge Clk);
    keycode = 8'h00;

    $display("[TB] clear patterns");
    applyStimulus(8'h2A, 1);
    @(negedge Clk);
    checkOutput("clear_channel0", 32'(channel0), 32'h000);
    applyStimulus(8'h1F, 1);
    applyStimulus(8'h2A, 1);
    @(negedge Clk);
    checkOutput("clear_channel1", 32'(channel1), 32'h000);
    trigSeen = 0;
    repeat (12 * 375 + 20) begin
      @(posedge Clk); #1;
      if (trig !== 4'b0000) trigSeen++;
    end
    checkOutput("clear_no_trig", 32'(trigSeen), 32'd0);

    $display("[TB] reset mid-play");
    applyStimulus(8'h20, 1);
    applyStimulus(8'h0C, 1);
    @(negedge Clk);
    checkOutput("arm_channel2", 32'(channel2), 32'h080);
    found = 0;
    n = 0;
    prevStep = step;
    while (!found && n < 12 * 375 + 20) begin
      @(posedge Clk); #1;
      n++;
      if (step == 4'd7 && prevStep != 4'd7) found = 1;
      prevStep = step;
    end
    checkOutput("reach_step7", 32'(found), 32'd1);
    checkOutput("step7_trig", 32'(trig), 32'b0100);
    #1 Reset_n = 1'b0;
    #1;
    checkOutput("async_step", 32'(step), 32'd0);
    checkOutput("async_playing", 32'(playing), 32'd0);
    checkOutput("async_trig", 32'(trig), 32'd0);
    checkOutput("async_channel2", 32'(channel2), 32'd0);
    checkOutput("async_bpm", 32'(bpm), 32'd120);
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    repeat (3) @(negedge Clk);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
